// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
// Flag indices follow the instruction_decoder one-hot class vector layout.
package cpu_ctrl_fsm_pkg;

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int FLAG_W_DEF      = 48;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_WAIT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    TC_ILLEGAL = 3'd0,
    TC_ECALL   = 3'd1,
    TC_EBREAK  = 3'd2,
    TC_IBUS    = 3'd3,
    TC_DBUS    = 3'd4
  } trap_cause_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_BR    = 2'd1,
    PC_JALR  = 2'd2,
    PC_TRAP  = 2'd3
  } pc_sel_t;

  // inst_flags bit positions
  localparam int F_BNE    = 47;
  localparam int F_BR_HI  = 47;
  localparam int F_BR_LO  = 42;
  localparam int F_BEQ    = 42;
  localparam int F_ADDI   = 41;
  localparam int F_LB     = 24;
  localparam int F_LH     = 23;
  localparam int F_LW     = 22;
  localparam int F_LBU    = 21;
  localparam int F_LHU    = 20;
  localparam int F_LD_HI  = 24;
  localparam int F_LD_LO  = 20;
  localparam int F_SB     = 19;
  localparam int F_SH     = 18;
  localparam int F_SW     = 17;
  localparam int F_ST_HI  = 19;
  localparam int F_ST_LO  = 17;
  localparam int F_CSRRW  = 16;
  localparam int F_MRET   = 10;
  localparam int F_WFI    = 9;
  localparam int F_SRET   = 8;
  localparam int F_ECALL  = 7;
  localparam int F_EBREAK = 6;
  localparam int F_JALR   = 5;
  localparam int F_JAL    = 4;
  localparam int F_LUI    = 2;
  localparam int F_SRL    = 0;

  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic ecall;
    logic ebreak;
    logic wfi;
    logic xret;
  } inst_cls_t;

  function automatic inst_cls_t classify(input logic [FLAG_W_DEF-1:0] f);
    inst_cls_t c;
    c.load   = |f[F_LD_HI:F_LD_LO];
    c.store  = |f[F_ST_HI:F_ST_LO];
    c.branch = |f[F_BR_HI:F_BR_LO];
    c.jal    = f[F_JAL];
    c.jalr   = f[F_JALR];
    c.ecall  = f[F_ECALL];
    c.ebreak = f[F_EBREAK];
    c.wfi    = f[F_WFI];
    c.xret   = f[F_MRET] | f[F_SRET];
    return c;
  endfunction

  function automatic pc_sel_t pc_target(input inst_cls_t c, input logic taken);
    pc_sel_t s;
    s = PC_PLUS4;
    if (c.branch) begin
      if (taken) s = PC_BR;
    end else if (c.jal) begin
      s = PC_BR;
    end else if (c.jalr) begin
      s = PC_JALR;
    end
    return s;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_timeout_cnt.sv
// Bus wait watchdog: counts cycles spent waiting for a memory ack and
// flags the last permitted cycle so the sequencer can trap if no ack arrives.
module cpu_ctrl_fsm_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !expire)
      cnt <= cnt + 1'b1;
  end

  // cnt is 0 on the first wait cycle, so LIMIT-1 marks the LIMIT-th cycle
  assign expire = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH->DECODE->EXEC->[MEM]->WB with
// trap handling (illegal/ecall/ebreak/bus timeout) and WFI stall.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int FLAG_W      = FLAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] inst_flags,
  input  logic              invalid_instruction,
  input  logic              imem_ack,
  input  logic              dmem_ack,
  input  logic              irq,
  input  logic              br_taken,    // ALU compare result, valid in EXEC
  output logic              imem_req,
  output logic              ir_load,
  output logic              dec_en,
  output logic              alu_go,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              rf_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic              trap,
  output logic [2:0]        trap_cause,
  output logic [2:0]        state_dbg
);

  state_t            state, state_nxt;
  trap_cause_t       cause_q, cause_nxt;
  logic [FLAG_W-1:0] flags_q;
  logic              taken_q;
  logic              cnt_clr, cnt_en, cnt_exp;
  inst_cls_t         cls;

  assign cls       = classify(flags_q);
  assign state_dbg = state;
  assign cnt_clr   = (state_nxt != state);

  cpu_ctrl_fsm_timeout_cnt #(.LIMIT(MEM_TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (cnt_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RESET;
      cause_q <= TC_ILLEGAL;
      flags_q <= '0;
      taken_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) cause_q <= cause_nxt;
      if (state == S_DECODE)   flags_q <= inst_flags;
      // WB drives pc_we after EXEC, so hold the compare result for it
      if (state == S_EXEC)     taken_q <= br_taken;
    end
  end

  always_comb begin
    state_nxt  = state;
    cause_nxt  = TC_ILLEGAL;
    cnt_en     = 1'b0;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dec_en     = 1'b0;
    alu_go     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    trap       = 1'b0;
    trap_cause = 3'd0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end else if (cnt_exp) begin
          state_nxt = S_TRAP;
          cause_nxt = TC_IBUS;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DECODE: begin
        dec_en = 1'b1;
        // zero or multiple class bits means a malformed decode
        if (invalid_instruction || !$onehot(inst_flags)) begin
          state_nxt = S_TRAP;
          cause_nxt = TC_ILLEGAL;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_go = 1'b1;
        if (cls.load || cls.store) begin
          state_nxt = S_MEM;
        end else if (cls.ecall) begin
          state_nxt = S_TRAP;
          cause_nxt = TC_ECALL;
        end else if (cls.ebreak) begin
          state_nxt = S_TRAP;
          cause_nxt = TC_EBREAK;
        end else if (cls.wfi) begin
          state_nxt = S_WAIT;
        end else begin
          pc_sel    = pc_target(cls, br_taken);
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls.store;
        if (dmem_ack) begin
          if (cls.store) begin
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (cnt_exp) begin
          state_nxt = S_TRAP;
          cause_nxt = TC_DBUS;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_WB: begin
        pc_we     = 1'b1;
        pc_sel    = pc_target(cls, taken_q);
        rf_we     = !(cls.branch || cls.store || cls.xret || cls.wfi ||
                      cls.ecall || cls.ebreak);
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
        pc_sel     = PC_TRAP;
        pc_we      = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_WAIT: begin
        if (irq) begin
          pc_we     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

endmodule
